riscv_ifu: RTL and testbench

Instruction fetch unit: the producer of the `ifu_vld`/`ifu` stream that the decode unit (IDU) consumes. It keeps the fetch PC, issues word reads on the instruction-memory request bus and tracks in-flight responses. Returned instructions are buffered in a small FIFO and presented to the IDU with a valid/ready handshake. A branch redirect flushes the FIFO, discards stale in-flight responses and restarts fetch at the new PC.

---
 rtl/riscv_ifu.sv | 116 +++++++++++
 tb/tb_riscv_ifu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ifu.sv
// Instruction fetch unit: issues word fetches, buffers returned instructions in a small FIFO
// and presents them to decode; branch redirects flush the buffer and drop stale responses.
package riscv_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifu_t;
endpackage

module riscv_ifu
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_vld,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_rdy,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_data,
  input  logic        bru_vld,
  input  logic [31:0] bru_pc,
  input  logic        idu_rdy,
  output logic        ifu_vld,
  output ifu_t        ifu
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
  localparam logic [CntW:0]   DepthW = (CntW + 1)'(FIFO_DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  ifu_t            fifo_q [FIFO_DEPTH];

  logic            req_fire, out_fire, push;
  logic [CntW:0]   credit_used;
  logic [31:0]     target_pc;

  always_comb begin
    // Credits cover both in-flight and buffered fetches, so a push can never overflow.
    credit_used   = {1'b0, outstanding_q} + {1'b0, count_q};
    imem_req_vld  = !reset && (credit_used < DepthW);
    imem_req_addr = fetch_pc_q;
    ifu_vld       = !reset && (count_q != '0);
    ifu           = fifo_q[rd_ptr_q];
    req_fire      = imem_req_vld && imem_req_rdy;
    out_fire      = ifu_vld && idu_rdy;
    // A response arriving alongside a redirect is already stale.
    push          = imem_rsp_vld && (discard_q == '0) && !bru_vld;
    target_pc     = bru_pc & ~32'h3;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_vld);
    count_d       = count_q + CntW'(push) - CntW'(out_fire);

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (imem_rsp_vld && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (out_fire) rd_ptr_d = rd_ptr_q + 1'b1;

    if (bru_vld) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      discard_d  = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: rsp_pc_q, instr: imem_rsp_data};
  end

  push_not_full: assert property (@(posedge clock) disable iff (reset)
    !(push && (count_q == DepthC)));

endmodule

// File: tb/tb_riscv_ifu.sv
// Bench for riscv_ifu: memory model with in-order responses, a scoreboard queue of expected
// {pc, instr}, a per-cycle vector table for the stall case and hand sequences for redirects.
module tb_riscv_ifu;
  import riscv_pkg::*;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_vld;
  logic [31:0] imem_req_addr;
  logic        imem_req_rdy;
  logic        imem_rsp_vld;
  logic [31:0] imem_rsp_data;
  logic        bru_vld;
  logic [31:0] bru_pc;
  logic        idu_rdy;
  logic        ifu_vld;
  ifu_t        ifu;

  riscv_ifu #(.RESET_PC(RstPc), .FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req_vld (imem_req_vld),
    .imem_req_addr(imem_req_addr),
    .imem_req_rdy (imem_req_rdy),
    .imem_rsp_vld (imem_rsp_vld),
    .imem_rsp_data(imem_rsp_data),
    .bru_vld      (bru_vld),
    .bru_pc       (bru_pc),
    .idu_rdy      (idu_rdy),
    .ifu_vld      (ifu_vld),
    .ifu          (ifu)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mrsp_t;

  typedef struct {
    logic        idu_rdy;
    logic        req_vld;
    logic        ifu_vld;
    logic [31:0] pc;
  } vec_t;

  mrsp_t       mem_q[$];
  ifu_t        exp_q[$];
  logic [31:0] exp_fetch_pc;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  bit          rand_rdy = 0;
  bit          last_rsp, last_req_fire, last_out;
  logic [31:0] last_out_pc;
  vec_t        tbl[14];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Drive memory outputs for this cycle, settle, then score the fires of this cycle.
  task automatic sample();
    bit    rf, of, rv;
    ifu_t  e;
    int    due;
    if (reset) begin
      mem_q.delete();
      exp_q.delete();
      exp_fetch_pc  = RstPc;
      imem_rsp_vld  = 1'b0;
      imem_rsp_data = '0;
    end else begin
      rv            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_rsp_vld  = rv;
      imem_rsp_data = rv ? mem_q[0].data : 32'h0;
    end
    imem_req_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    rf            = imem_req_vld && imem_req_rdy;
    of            = ifu_vld && idu_rdy;
    last_rsp      = imem_rsp_vld;
    last_req_fire = rf;
    last_out      = of;
    last_out_pc   = ifu.pc;
    if (!reset) begin
      if (of) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got pc %h want none (cycle %0d)", ifu.pc, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", ifu.pc, e.pc);
          check("out_instr", ifu.instr, e.instr);
        end
      end
      if (imem_rsp_vld) void'(mem_q.pop_front());
      if (rf) begin
        check("req_addr", imem_req_addr, exp_fetch_pc);
        due = cyc + mem_lat;
        if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
        mem_q.push_back('{data: mem_word(imem_req_addr), due: due});
      end
      if (bru_vld) begin
        exp_q.delete();
        exp_fetch_pc = bru_pc & ~32'h3;
      end else if (rf) begin
        exp_q.push_back('{pc: exp_fetch_pc, instr: mem_word(exp_fetch_pc)});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic wait_out(input string name, input logic [31:0] want);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      sample();
      if (last_out) begin
        got = 1;
        check(name, last_out_pc, want);
      end
      advance();
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no output want pc %h", name, want);
    end
  endtask

  initial begin
    int n;
    // Stall vectors starting the first cycle after reset falls, 1-cycle memory.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h100};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h100};
    for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 32'h100};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h100};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h104};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h108};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h10C};

    reset         = 1'b1;
    idu_rdy       = 1'b0;
    bru_vld       = 1'b0;
    bru_pc        = '0;
    imem_req_rdy  = 1'b1;
    imem_rsp_vld  = 1'b0;
    imem_rsp_data = '0;
    exp_fetch_pc  = RstPc;
    @(posedge clock);
    #1;
    tick(2);
    sample();
    check("rst_req_vld", 32'(imem_req_vld), 32'd0);
    check("rst_ifu_vld", 32'(ifu_vld), 32'd0);
    advance();
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      idu_rdy = tbl[i].idu_rdy;
      sample();
      check($sformatf("vec%0d_req_vld", i), 32'(imem_req_vld), 32'(tbl[i].req_vld));
      check($sformatf("vec%0d_ifu_vld", i), 32'(ifu_vld), 32'(tbl[i].ifu_vld));
      if (tbl[i].ifu_vld) check($sformatf("vec%0d_pc", i), ifu.pc, tbl[i].pc);
      advance();
    end

    n = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (last_out) n++;
      advance();
    end
    check("throughput", 32'(n), 32'd10);

    // Redirect with 3-cycle memory and responses in flight.
    mem_lat = 3;
    tick(8);
    bru_vld = 1'b1;
    bru_pc  = 32'h2003;
    sample();
    advance();
    bru_vld = 1'b0;
    sample();
    check("redir_ifu_vld", 32'(ifu_vld), 32'd0);
    check("redir_req_addr", imem_req_addr, 32'h2000);
    advance();
    wait_out("redir_first", 32'h2000);
    wait_out("redir_second", 32'h2004);

    // Redirect coinciding with a response and a request fire.
    mem_lat = 1;
    tick(6);
    bru_vld = 1'b1;
    bru_pc  = 32'h3000;
    sample();
    check("redir_rsp_req_same_cycle", {30'd0, last_rsp, last_req_fire}, 32'd3);
    advance();
    bru_vld = 1'b0;
    wait_out("redir2_first", 32'h3000);
    wait_out("redir2_second", 32'h3004);

    // Back-to-back redirects: the last one wins.
    mem_lat = 3;
    bru_vld = 1'b1;
    bru_pc  = 32'h4000;
    sample();
    advance();
    bru_pc  = 32'h5000;
    sample();
    advance();
    bru_vld = 1'b0;
    wait_out("b2b_redir", 32'h5000);

    // PC wrap at the top of the address space.
    mem_lat = 1;
    bru_vld = 1'b1;
    bru_pc  = 32'hFFFF_FFF8;
    sample();
    advance();
    bru_vld = 1'b0;
    wait_out("wrap_fff8", 32'hFFFF_FFF8);
    wait_out("wrap_fffc", 32'hFFFF_FFFC);
    wait_out("wrap_0", 32'h0000_0000);
    wait_out("wrap_4", 32'h0000_0004);

    // Reset with fetches in flight and a partly full buffer.
    mem_lat = 3;
    idu_rdy = 1'b0;
    tick(6);
    reset = 1'b1;
    sample();
    check("midrst_ifu_vld", 32'(ifu_vld), 32'd0);
    check("midrst_req_vld", 32'(imem_req_vld), 32'd0);
    advance();
    sample();
    check("midrst_ifu_vld2", 32'(ifu_vld), 32'd0);
    check("midrst_req_vld2", 32'(imem_req_vld), 32'd0);
    advance();
    reset   = 1'b0;
    idu_rdy = 1'b1;
    wait_out("after_reset", RstPc);

    // Random backpressure, bus stalls and occasional redirects.
    mem_lat  = 2;
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      idu_rdy = 1'($urandom_range(0, 1));
      bru_vld = ($urandom_range(0, 99) < 3);
      bru_pc  = $urandom();
      sample();
      advance();
    end
    rand_rdy = 0;
    bru_vld  = 1'b0;
    idu_rdy  = 1'b1;
    tick(20);
    idu_rdy = 1'b0;
    tick(12);
    check("buffered_after_stall", 32'(ifu_vld), 32'd1);
    idu_rdy = 1'b1;
    tick(1);
    check("drain_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
